scan_link_sched: RTL
====================

SCAN_LINK_SCHED -- requirements
Module: scan_link_sched

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: req  input  2  per-scanner transfer request, level, bit n = scanner n.
REQ-004 SHALL have port: cmd0, cmd1  input  8 each  command byte offered by scanner 0/1.
REQ-005 SHALL have port: data0, data1  input  8 each  payload byte offered by scanner 0/1.
REQ-006 SHALL have port: readyForTransferIn  input  1  far end ready to accept bytes.
REQ-007 SHALL have port: dataOut  output  1  serial link bit, MSB first.
REQ-008 SHALL have port: grant  output  2  one-hot owner of the link; 0 when idle.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a granted transfer completes.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: frameCount  output  3  free-running bit-slot counter.

Function
REQ-012 SHALL run frameCount +1 every cycle and wrap 7->0; a byte SHALL start only on a cycle where frameCount==0.
REQ-013 SHALL implement states IDLE, WAIT_FRAME, SEND_CMD, SEND_DATA, GAP.
REQ-014 IDLE: if any req bit is high, SHALL latch the winner's cmd/data bytes, set grant, and go to WAIT_FRAME.
REQ-015 Arbitration SHALL be round-robin: a pointer names the preferred scanner; if both req are high, the preferred one wins; the pointer SHALL move to the other scanner after each done.
REQ-016 If only one req is high, that scanner SHALL win regardless of the pointer.
REQ-017 WAIT_FRAME: on the cycle frameCount==7, SHALL go to SEND_CMD, so bit 7 drives dataOut when frameCount==0.
REQ-018 SEND_CMD: SHALL drive the latched cmd bit (7 - frameCount), one bit per cycle, for exactly 8 cycles.
REQ-019 After SEND_CMD, SHALL go to SEND_DATA if latched cmd == CMD_BINARY (8'd7); otherwise it SHALL go to GAP.
REQ-020 SEND_DATA: SHALL drive the latched data byte MSB first for 8 cycles, aligned to the next frame, then go to GAP.
REQ-021 GAP: SHALL drive dataOut=0 for one full frame (8 cycles), so the far end sees an all-zero byte; it SHALL pulse done on the first GAP cycle, clear grant at GAP exit, and return to IDLE.
REQ-022 dataOut SHALL be 0 in IDLE, WAIT_FRAME and GAP.
REQ-023 cmd/data inputs and req changes after the latch SHALL NOT affect the transfer in flight; deasserting req mid-transfer SHALL NOT abort it.
REQ-024 A latched cmd of 8'd0 SHALL still be transmitted (8 zero bits); no special handling.
REQ-025 A new grant SHALL be possible on the cycle after GAP exit; there SHALL be no lost request when req is held high.

Reset
REQ-026 While rst=1: state=IDLE, grant=0, done=0, busy=0, dataOut=0, frameCount=0, round-robin pointer=scanner 0, latched bytes=0.
REQ-027 rst asserted mid-transfer SHALL abandon the transfer on the next edge with no done pulse.

Configuration
REQ-028 Macro LINK_READY_GATE_EN: when defined, IDLE SHALL grant only while readyForTransferIn=1, and the block SHALL hold in WAIT_FRAME while readyForTransferIn=0; when not defined, readyForTransferIn SHALL be ignored (port kept, unused).

Structure
REQ-029 Package scan_link_pkg SHALL hold the command codes (CMD_BUF50=1, CMD_BUF80=2, CMD_BUF90=3, CMD_FULL=4, CMD_FLUSH=5, CMD_READY=6, CMD_BINARY=7, CMD_ASCII=8), the state enum, and FRAME_BITS=8.
REQ-030 Sub-module link_shift8 (8-bit parallel-load, MSB-first shifter) SHALL be instantiated once and shared by SEND_CMD and SEND_DATA.

Verification
REQ-031 After reset, req=2'b01 with cmd0=8'h03 -> grant=01; dataOut carries 00000011 over one frame, then an 8-cycle zero gap; done pulses once; no data byte is sent.
REQ-032 req=2'b10 with cmd1=8'h07 and data1=8'hA5 -> frames 00000111 then 10100101, then the gap; grant=10 throughout.
REQ-033 req=2'b11 held high with both cmd=8'h01 -> grants alternate 01,10,01,10 over four transfers, with exactly one done per transfer.
REQ-034 rst pulsed during SEND_DATA of bit 4 -> next cycle grant=0, dataOut=0, busy=0, frameCount=0, and no done pulse.
REQ-035 LINK_READY_GATE_EN defined, readyForTransferIn=0, req=01 -> no grant; raise readyForTransferIn -> grant next cycle and the first bit is aligned to frameCount==0.
REQ-036 cmd0 changed from 8'h07 to 8'h02 one cycle after grant -> the transmitted byte is still 00000111 and the data byte still follows.

Source files
------------

// File: rtl/scan_link_pkg.sv
// Shared definitions for the scanner link scheduler: command codes, FSM states, frame geometry.
package scan_link_pkg;

  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned FC_W       = 3;
  localparam int unsigned REQ_W      = 2;

  localparam logic [FRAME_BITS-1:0] CMD_BUF50  = 8'd1;
  localparam logic [FRAME_BITS-1:0] CMD_BUF80  = 8'd2;
  localparam logic [FRAME_BITS-1:0] CMD_BUF90  = 8'd3;
  localparam logic [FRAME_BITS-1:0] CMD_FULL   = 8'd4;
  localparam logic [FRAME_BITS-1:0] CMD_FLUSH  = 8'd5;
  localparam logic [FRAME_BITS-1:0] CMD_READY  = 8'd6;
  localparam logic [FRAME_BITS-1:0] CMD_BINARY = 8'd7;
  localparam logic [FRAME_BITS-1:0] CMD_ASCII  = 8'd8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SEND_CMD,
    SEND_DATA,
    GAP
  } state_e;

  // Bytes captured from the winning scanner at grant time.
  typedef struct packed {
    logic [FRAME_BITS-1:0] cmd;
    logic [FRAME_BITS-1:0] data;
  } xfer_t;

endpackage

// File: rtl/link_shift8.sv
// 8-bit parallel-load shifter with a registered MSB-first serial output; output is 0 when neither loading nor shifting.
module link_shift8
  import scan_link_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAME_BITS-1:0] din,
  output logic                  q
);

  logic [FRAME_BITS-2:0] rest;

  // q carries the current bit; rest holds the bits still to go, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= 1'b0;
      rest <= '0;
    end else if (load) begin
      q    <= din[FRAME_BITS-1];
      rest <= din[FRAME_BITS-2:0];
    end else if (shift) begin
      q    <= rest[FRAME_BITS-2];
      rest <= {rest[FRAME_BITS-3:0], 1'b0};
    end else begin
      q    <= 1'b0;
      rest <= '0;
    end
  end

endmodule

// File: rtl/scan_link_sched.sv
// Round-robin scheduler of two scanners onto one framed serial link.
// Optional LINK_READY_GATE_EN: gate granting and frame start on readyForTransferIn.
module scan_link_sched
  import scan_link_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_W-1:0]      req,
  input  logic [FRAME_BITS-1:0] cmd0,
  input  logic [FRAME_BITS-1:0] cmd1,
  input  logic [FRAME_BITS-1:0] data0,
  input  logic [FRAME_BITS-1:0] data1,
  input  logic                  readyForTransferIn,
  output logic                  dataOut,
  output logic [REQ_W-1:0]      grant,
  output logic                  done,
  output logic                  busy,
  output logic [FC_W-1:0]       frameCount
);

  state_e           state, state_nxt;
  xfer_t            lat, lat_nxt;
  logic [REQ_W-1:0] grant_nxt;
  logic             ptr, ptr_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             win;
  logic             load, shift;
  logic [FRAME_BITS-1:0] shift_din;
  logic             frame_last;
  logic             link_ready;

`ifdef LINK_READY_GATE_EN
  assign link_ready = readyForTransferIn;
`else
  logic unused_ready;
  assign link_ready   = 1'b1;
  assign unused_ready = readyForTransferIn;
`endif

  assign frame_last = (frameCount == FC_W'(FRAME_BITS - 1));

  // Next-state, arbitration and shifter control.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    win       = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    shift_din = lat.cmd;
    case (state)
      IDLE: begin
        if ((|req) && link_ready) begin
          win       = (req == 2'b11) ? ptr : req[1];
          lat_nxt   = win ? {cmd1, data1} : {cmd0, data0};
          grant_nxt = win ? 2'b10 : 2'b01;
          state_nxt = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_last && link_ready) begin
          load      = 1'b1;
          state_nxt = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (!frame_last) begin
          shift = 1'b1;
        end else if (lat.cmd == CMD_BINARY) begin
          load      = 1'b1;
          shift_din = lat.data;
          state_nxt = SEND_DATA;
        end else begin
          done_nxt  = 1'b1;
          ptr_nxt   = ~ptr;
          state_nxt = GAP;
        end
      end
      SEND_DATA: begin
        if (!frame_last) begin
          shift = 1'b1;
        end else begin
          done_nxt  = 1'b1;
          ptr_nxt   = ~ptr;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (frame_last) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat        <= '0;
      grant      <= '0;
      ptr        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      frameCount <= '0;
    end else begin
      state      <= state_nxt;
      lat        <= lat_nxt;
      grant      <= grant_nxt;
      ptr        <= ptr_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      frameCount <= frameCount + FC_W'(1);
    end
  end

  link_shift8 u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (shift_din),
    .q     (dataOut)
  );

endmodule
